// File: rtl/esi_manifest_streamer.sv
// esi_manifest_streamer: streams the compressed ESI manifest from a byte ROM
// as 64-bit words, preceded by a header word {MAGIC, 16'h0, size}.
// Ports:
//   clk, rst             clock, async active-high reset
//   start                one-cycle request to (re)stream the manifest
//   rom_en/rom_addr      ROM read request (byte address)
//   rom_data             ROM byte, valid one cycle after rom_en
//   out_valid/out_ready  output word handshake
//   out_data/out_last    output word and end-of-transfer marker
//   busy/done            status (busy in HDR/FILL/SEND, done in DONE)
module esi_manifest_streamer #(
    parameter int          MANIFEST_SIZE = 0,
    parameter logic [31:0] MAGIC         = 32'h4553494D
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        rom_en,
    output logic [15:0] rom_addr,
    input  logic [7:0]  rom_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        out_last,
    output logic        busy,
    output logic        done
);

    localparam logic [16:0] SZ  = 17'(MANIFEST_SIZE);
    localparam logic [63:0] HDR_WORD = {MAGIC, 16'h0, SZ[15:0]};

    typedef enum logic [2:0] {IDLE, HDR, FILL, SEND, DONE} state_t;

    state_t      r_state;
    logic [16:0] r_addr;
    logic [3:0]  r_issue;
    logic        r_pend;
    logic [15:0] r_paddr;
    logic [63:0] r_pack;
    logic        r_rom_en;
    logic [15:0] r_rom_addr;
    logic        r_valid;
    logic [63:0] r_data;
    logic        r_last;
    logic        r_busy;
    logic        r_done;

    logic [63:0] w_pack;
    logic        w_eof;
    logic        w_final;
    logic        w_can_issue;

    // r_pend/r_paddr describe the byte on rom_data this cycle.
    always_comb begin
        w_pack = r_pack;
        w_pack[{r_paddr[2:0], 3'b000} +: 8] = rom_data;
        w_eof       = (17'(r_paddr) + 17'd1) == SZ;
        w_final     = r_pend && ((r_paddr[2:0] == 3'd7) || w_eof);
        w_can_issue = (r_addr < SZ) && (r_issue < 4'd8);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_issue    <= '0;
            r_pend     <= 1'b0;
            r_paddr    <= '0;
            r_pack     <= '0;
            r_rom_en   <= 1'b0;
            r_rom_addr <= '0;
            r_valid    <= 1'b0;
            r_data     <= '0;
            r_last     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_pend  <= r_rom_en;
            r_paddr <= r_rom_addr;
            unique case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state <= HDR;
                        r_addr  <= '0;
                        r_valid <= 1'b1;
                        r_data  <= HDR_WORD;
                        r_last  <= (SZ == 17'd0);
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end
                end
                HDR: begin
                    if (out_ready) begin
                        r_valid <= 1'b0;
                        r_data  <= '0;
                        r_last  <= 1'b0;
                        if (SZ == 17'd0) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            // First read issues on the first FILL cycle.
                            r_state    <= FILL;
                            r_rom_en   <= 1'b1;
                            r_rom_addr <= r_addr[15:0];
                            r_addr     <= r_addr + 17'd1;
                            r_issue    <= 4'd1;
                            r_pack     <= '0;
                        end
                    end
                end
                FILL: begin
                    if (w_can_issue) begin
                        r_rom_en   <= 1'b1;
                        r_rom_addr <= r_addr[15:0];
                        r_addr     <= r_addr + 17'd1;
                        r_issue    <= r_issue + 4'd1;
                    end else begin
                        r_rom_en <= 1'b0;
                    end
                    if (r_pend) begin
                        r_pack <= w_pack;
                    end
                    if (w_final) begin
                        r_state <= SEND;
                        r_valid <= 1'b1;
                        r_data  <= w_pack;
                        r_last  <= w_eof;
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        r_valid <= 1'b0;
                        r_data  <= '0;
                        r_last  <= 1'b0;
                        if (r_last) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state    <= FILL;
                            r_rom_en   <= 1'b1;
                            r_rom_addr <= r_addr[15:0];
                            r_addr     <= r_addr + 17'd1;
                            r_issue    <= 4'd1;
                            r_pack     <= '0;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign rom_en    = r_rom_en;
    assign rom_addr  = r_rom_addr;
    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_last  = r_last;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_esi_manifest_streamer.sv
// tb_esi_manifest_streamer: scoreboard bench for esi_manifest_streamer,
// one DUT per manifest size (13, 0, 16, 8), each with a byte ROM model.
module tb_esi_manifest_streamer;

    localparam logic [31:0] MAGIC = 32'h4553494D;
    localparam int SIZES [4] = '{13, 0, 16, 8};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  start = '0;
    logic        ready_v = 1'b1;
    logic        stall_mode = 1'b0;
    logic [3:0]  rom_en, oval, olast, busy, done;
    logic [15:0] raddr [4];
    logic [63:0] odat [4];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        logic [7:0] q;
        always @(posedge clk) begin
            if (rom_en[g]) q <= 8'hA0 + raddr[g][7:0];
        end
        esi_manifest_streamer #(.MANIFEST_SIZE(SIZES[g])) u_dut (
            .clk       (clk),
            .rst       (rst),
            .start     (start[g]),
            .rom_en    (rom_en[g]),
            .rom_addr  (raddr[g]),
            .rom_data  (q),
            .out_valid (oval[g]),
            .out_ready (ready_v),
            .out_data  (odat[g]),
            .out_last  (olast[g]),
            .busy      (busy[g]),
            .done      (done[g])
        );
    end

    logic [1:0]  sel = '0;
    logic        vs, ls, es, bs, dn;
    logic [63:0] ds;
    logic [15:0] as;
    always_comb begin
        vs = oval[sel];
        ls = olast[sel];
        es = rom_en[sel];
        bs = busy[sel];
        dn = done[sel];
        ds = odat[sel];
        as = raddr[sel];
    end

    logic [64:0] exp_q [$];
    int n_vec = 0;
    int n_err = 0;
    int exp_addr = 0;
    int rd_cnt = 0;
    logic        held = 1'b0;
    logic [63:0] hdat;
    logic        hlast;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Output/ROM monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (es) begin
                check("rom_addr", 64'(as), 64'(exp_addr));
                exp_addr++;
                rd_cnt++;
            end
            if (held) begin
                check("stall_valid", 64'(vs), 64'd1);
                check("stall_data", ds, hdat);
                check("stall_last", 64'(ls), 64'(hlast));
            end
            if (vs && ready_v) begin
                held = 1'b0;
                if (exp_q.size() == 0) begin
                    check("extra_word", 64'(vs), 64'd0);
                end else begin
                    logic [64:0] e;
                    e = exp_q.pop_front();
                    check("word_data", ds, e[63:0]);
                    check("word_last", 64'(ls), 64'(e[64]));
                end
            end else if (vs) begin
                held  = 1'b1;
                hdat  = ds;
                hlast = ls;
            end else begin
                held = 1'b0;
            end
        end
    end

    // Consumer: always ready, or 5 stall cycles per valid word.
    initial begin
        int cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!stall_mode) begin
                ready_v = 1'b1;
                cnt = 0;
            end else if (vs) begin
                if (cnt == 5) begin
                    ready_v = 1'b1;
                    cnt = 0;
                end else begin
                    ready_v = 1'b0;
                    cnt++;
                end
            end else begin
                ready_v = 1'b0;
                cnt = 0;
            end
        end
    end

    task automatic push_exp(int size);
        int nw;
        logic [63:0] w;
        exp_q.push_back({(size == 0), MAGIC, 16'h0, 16'(size)});
        nw = (size + 7) / 8;
        for (int i = 0; i < nw; i++) begin
            w = '0;
            for (int b = 0; b < 8; b++) begin
                int idx;
                idx = i * 8 + b;
                if (idx < size) w[8*b +: 8] = 8'hA0 + 8'(idx);
            end
            exp_q.push_back({(i == nw - 1), w});
        end
    endtask

    task automatic pulse(int k);
        @(posedge clk);
        #1;
        start[k] = 1'b1;
        @(posedge clk);
        #1;
        start[k] = 1'b0;
    endtask

    task automatic xfer(int k, int size, bit mid);
        int c;
        sel = 2'(k);
        exp_addr = 0;
        rd_cnt = 0;
        push_exp(size);
        pulse(k);
        c = 0;
        while (c < 500 && !(exp_q.size() == 0 && dn)) begin
            @(posedge clk);
            #1;
            start[k] = mid && (c == 4);
            c++;
        end
        start[k] = 1'b0;
        check("timeout", 64'(exp_q.size()), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check("done", 64'(dn), 64'd1);
        check("busy", 64'(bs), 64'd0);
        check("rom_reads", 64'(rd_cnt), 64'(size));
        check("leftover", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #1;
        check("rst_rom_en", 64'(rom_en[0]), 64'd0);
        check("rst_addr", 64'(raddr[0]), 64'd0);
        check("rst_valid", 64'(oval[0]), 64'd0);
        check("rst_data", odat[0], 64'd0);
        check("rst_last", 64'(olast[0]), 64'd0);
        check("rst_busy", 64'(busy[0]), 64'd0);
        check("rst_done", 64'(done[0]), 64'd0);
        #20;
        rst = 1'b0;

        xfer(0, 13, 1'b0);
        stall_mode = 1'b1;
        xfer(0, 13, 1'b0);
        stall_mode = 1'b0;
        xfer(1, 0, 1'b0);
        xfer(2, 16, 1'b1);
        xfer(2, 16, 1'b0);

        // Async reset in the middle of FILL.
        sel = 2'd0;
        exp_addr = 0;
        rd_cnt = 0;
        push_exp(13);
        pulse(0);
        for (int c = 0; c < 50 && rd_cnt < 3; c++) @(posedge clk);
        check("mid_fill", 64'(rd_cnt >= 3), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_rom_en", 64'(rom_en[0]), 64'd0);
        check("arst_valid", 64'(oval[0]), 64'd0);
        check("arst_data", odat[0], 64'd0);
        check("arst_last", 64'(olast[0]), 64'd0);
        check("arst_busy", 64'(busy[0]), 64'd0);
        check("arst_done", 64'(done[0]), 64'd0);
        exp_q.delete();
        held = 1'b0;
        #10;
        rst = 1'b0;
        xfer(0, 13, 1'b0);

        xfer(3, 8, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/esi_manifest_streamer.md
Name: esi_manifest_streamer

Overview:
- Sequences delivery of the zlib-compressed ESI manifest from an on-chip byte ROM to the host-facing channel as 64-bit words, preceded by one header word carrying a magic value and the byte count.
- Sits between the manifest ROM (synchronous, 1-cycle read latency) and the ESI manifest read channel.
- Host-triggered via `start`. Replaces the cosim-only manifest hand-off for synthesizable builds.

Parameters:
- MANIFEST_SIZE, default 0: compressed manifest length in bytes (0..65535).
- MAGIC, default 32'h4553494D: header upper half ("ESIM").

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to (re)stream the manifest.
- rom_en  out  1  ROM read enable.
- rom_addr  out  16  ROM byte address.
- rom_data  in  8  ROM read data, valid exactly 1 cycle after rom_en.
- out_valid  out  1  output word valid.
- out_ready  in  1  consumer ready.
- out_data  out  64  output word.
- out_last  out  1  marks the final word of a transfer.
- busy  out  1  high in all states except IDLE and DONE.
- done  out  1  high in DONE.

Behaviour:
- Reset (asynchronous assert): state IDLE; rom_en=0, rom_addr=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0; byte/lane counters and pack register cleared. Reset asserted mid-transfer aborts it; no partial word is presented afterwards.
- States: IDLE, HDR, FILL, SEND, DONE.
- IDLE/DONE:
  - start=1 -> HDR next cycle.
  - done stays 1 in DONE until start.
- HDR:
  - out_valid=1; out_data={MAGIC, 16'h0, MANIFEST_SIZE[15:0]}; out_last=(MANIFEST_SIZE==0).
  - On out_valid&&out_ready: next state is DONE if size 0, else FILL with byte address 0.
- FILL:
  - Each cycle, while issued-address < MANIFEST_SIZE and lane issue count < 8: rom_en=1, rom_addr=address, address++.
  - Returned byte lands in lane (address mod 8), little-endian: byte 0 goes to out_data[7:0].
  - Pack register is zeroed on FILL entry, so lanes never written read as 0.
  - When the last byte of the word has been captured (8 bytes, or the final manifest byte) -> SEND.
  - A full word costs 8 issue cycles + 1 latency cycle.
- SEND:
  - out_valid=1; out_data=pack register; out_last=1 iff the word contains byte MANIFEST_SIZE-1.
  - On handshake: DONE if last, else FILL.
- Handshake rules:
  - out_data and out_last are held stable while out_valid && !out_ready.
  - out_valid never drops without a handshake.
  - rom_en=0 outside FILL.
- start while busy is ignored; there is no queueing.
- Word count = 1 + ceil(MANIFEST_SIZE/8). The address counter never exceeds MANIFEST_SIZE, so there is no wrap.
- start coincident with the final SEND handshake: go to DONE, and start is dropped.

Test Plan:
- MANIFEST_SIZE=13, ROM byte i = 8'hA0+i, out_ready=1, pulse start:
  - header 64'h4553494D_0000000D with out_last=0;
  - word 64'hA7A6A5A4A3A2A1A0 with last=0;
  - word 64'h000000ACABAAA9A8 with last=1;
  - done=1 afterwards and busy=0.
- Same config with out_ready toggled low for 5 cycles during each valid -> out_data/out_last stable while stalled; identical 3-word sequence; no extra rom_en beyond 13 reads total.
- MANIFEST_SIZE=0, start -> single header 64'h4553494D_00000000 with out_last=1, then done=1, with rom_en never asserted.
- MANIFEST_SIZE=16, start; then start pulsed again during FILL; after DONE, start again:
  - exactly 3 words per transfer (last on word 3);
  - the mid-transfer start has no effect;
  - the second transfer is bit-identical to the first.
- MANIFEST_SIZE=13, assert rst asynchronously mid-FILL (between clock edges) -> all outputs 0 immediately. Then start -> clean full 3-word transfer starting from the header.
- MANIFEST_SIZE=8 -> header, one word 64'hA7..A0 with last=1, exactly 8 ROM reads at addresses 0..7 in order.
